// File: rtl/clk_gate_en_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_en_ctrl_pkg
//  Description : Shared types and default parameter values for the clock-gate
//                enable controller (FSM state encoding, demand helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_gate_en_ctrl_pkg;

    localparam int c_idle_w_default   = 8;
    localparam int c_wake_dly_default = 2;
    localparam int c_gcnt_w_default   = 16;

    // Width of the wake-delay counter; large enough for the full 1..15 range
    localparam int c_wake_cnt_w       = 4;

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKE      = 2'd3
    } state_t;

    // Any source that needs the gated clock running
    function automatic logic has_demand(input logic busy,
                                        input logic wake_req,
                                        input logic force_on);
        return busy | wake_req | force_on;
    endfunction

    // States in which the consumer clock is fully up and a wake can be acked
    function automatic logic is_awake_state(input state_t s);
        return (s == ST_ACTIVE) || (s == ST_IDLE_WAIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gate_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_idle_timer
//  Description : Idle-cycle counter with load/clear/increment controls and a
//                compare against the programmable idle threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_idle_timer
    import clk_gate_en_ctrl_pkg::*;
#(
    parameter int IDLE_W = c_idle_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [IDLE_W-1:0] i_thresh,
    output logic              o_reached
);

    logic [IDLE_W-1:0] r_count;

    // Idle counter: clear has priority, load starts a new idle run at 1
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= IDLE_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Greater-or-equal so that lowering the threshold mid-run gates promptly.
    // The counter never passes a nonzero threshold, so it cannot wrap.
    assign o_reached = (i_thresh != '0) && (r_count >= i_thresh);

endmodule

`default_nettype wire

// File: rtl/clk_gate_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_en_ctrl
//  Description : Clock-gate enable controller. Gates the consumer clock after
//                a programmable number of idle cycles, re-enables it on
//                demand with a fixed wake delay, acknowledges a four-phase
//                wake handshake and counts gating events (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_en_ctrl
    import clk_gate_en_ctrl_pkg::*;
#(
    parameter int IDLE_W   = c_idle_w_default,
    parameter int WAKE_DLY = c_wake_dly_default,
    parameter int GCNT_W   = c_gcnt_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              force_on,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              en,
    output logic              wake_ack,
    output logic              gated,
    output logic [GCNT_W-1:0] gate_cnt
);

    // Last wake-counter value before returning to ACTIVE
    localparam logic [c_wake_cnt_w-1:0] c_wake_last = c_wake_cnt_w'(WAKE_DLY - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_demand;
    logic                    w_idle_load;
    logic                    w_idle_clr;
    logic                    w_idle_inc;
    logic                    w_idle_reached;
    logic                    w_gate_evt;
    logic [c_wake_cnt_w-1:0] r_wake_cnt;
    logic                    r_en;
    logic                    r_wake_ack;
    logic                    r_gated;
    logic [GCNT_W-1:0]       r_gate_cnt;

    assign w_demand = has_demand(busy, wake_req, force_on);

    clk_gate_idle_timer #(
        .IDLE_W    (IDLE_W)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_idle_load),
        .i_clr     (w_idle_clr),
        .i_inc     (w_idle_inc),
        .i_thresh  (idle_thresh),
        .o_reached (w_idle_reached)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and idle-timer controls
    always_comb begin
        w_state_nxt = r_state;
        w_idle_load = 1'b0;
        w_idle_clr  = 1'b0;
        w_idle_inc  = 1'b0;
        w_gate_evt  = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (!w_demand && (idle_thresh != '0)) begin
                    w_state_nxt = ST_IDLE_WAIT;
                    w_idle_load = 1'b1;
                end
            end
            ST_IDLE_WAIT: begin
                // Demand beats a simultaneous threshold match
                if (w_demand || (idle_thresh == '0)) begin
                    w_state_nxt = ST_ACTIVE;
                    w_idle_clr  = 1'b1;
                end else if (w_idle_reached) begin
                    w_state_nxt = ST_GATED;
                    w_idle_clr  = 1'b1;
                    w_gate_evt  = 1'b1;
                end else begin
                    w_idle_inc  = 1'b1;
                end
            end
            ST_GATED: begin
                if (w_demand) begin
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                // Fixed wake delay, independent of whether demand persists
                if (r_wake_cnt == c_wake_last) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // Wake-delay counter: runs only while in WAKE, zero on entry
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAKE)) begin
            r_wake_cnt <= '0;
        end else begin
            r_wake_cnt <= r_wake_cnt + 1'b1;
        end
    end

    // Registered outputs decoded from the next state, plus saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en       <= 1'b1;
            r_wake_ack <= 1'b0;
            r_gated    <= 1'b0;
            r_gate_cnt <= '0;
        end else begin
            r_en       <= (w_state_nxt != ST_GATED);
            r_gated    <= (w_state_nxt == ST_GATED);
            r_wake_ack <= wake_req & is_awake_state(w_state_nxt);
            if (w_gate_evt && (r_gate_cnt != '1)) begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
            end
        end
    end

    assign en       = r_en;
    assign wake_ack = r_wake_ack;
    assign gated    = r_gated;
    assign gate_cnt = r_gate_cnt;

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_gate_en_ctrl
//  Description : Self-checking bench for clk_gate_en_ctrl. A default-width
//                instance and a GCNT_W=4 instance share all stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_en_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        wake_req;
    logic        force_on;
    logic [7:0]  idle_thresh;

    logic        en, wake_ack, gated;
    logic [15:0] gate_cnt;
    logic        s_en, s_wake_ack, s_gated;
    logic [3:0]  s_gate_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_gc  = 0;

    typedef struct packed {
        logic        en;
        logic        gated;
        logic        ack;
        logic [15:0] cnt;
        logic [3:0]  scnt;
    } exp_t;

    exp_t sb[$];
    exp_t e, o;

    clk_gate_en_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .busy        (busy),
        .wake_req    (wake_req),
        .force_on    (force_on),
        .idle_thresh (idle_thresh),
        .en          (en),
        .wake_ack    (wake_ack),
        .gated       (gated),
        .gate_cnt    (gate_cnt)
    );

    clk_gate_en_ctrl #(
        .GCNT_W      (4)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .busy        (busy),
        .wake_req    (wake_req),
        .force_on    (force_on),
        .idle_thresh (idle_thresh),
        .en          (s_en),
        .wake_ack    (s_wake_ack),
        .gated       (s_gated),
        .gate_cnt    (s_gate_cnt)
    );

    always #5 clk = ~clk;

    // Expected output tuple; the 4-bit instance saturates at 15
    function automatic exp_t mk(input logic xe, input logic xg, input logic xa, input int gc);
        exp_t r;
        r.en   = xe;
        r.gated = xg;
        r.ack  = xa;
        r.cnt  = 16'(gc);
        r.scnt = (gc > 15) ? 4'd15 : 4'(gc);
        return r;
    endfunction

    function automatic exp_t obs();
        exp_t r;
        r.en   = en;
        r.gated = gated;
        r.ack  = wake_ack;
        r.cnt  = gate_cnt;
        r.scnt = s_gate_cnt;
        return r;
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; busy = 1'b0; wake_req = 1'b1; force_on = 1'b0; idle_thresh = 8'd1;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        tick(3);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_state: got %h exp %h", o, e); end
        rst = 1'b0; busy = 1'b1; wake_req = 1'b0; idle_thresh = 8'd4;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL post_reset_active: got %h exp %h", o, e); end
    endtask

    task automatic test_gating_latency();
        idle_thresh = 8'd4;
        busy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
            tick(1);
            e = sb.pop_front(); o = obs(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL gate_wait_%0d: got %h exp %h", k, o, e); end
        end
        exp_gc++;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, exp_gc));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL gate_latency: got %h exp %h", o, e); end
    endtask

    task automatic test_wake();
        logic exp_ack [6];
        exp_ack = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        wake_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                wake_req = 1'b0;
                busy     = 1'b1;
            end
            sb.push_back(mk(1'b1, 1'b0, exp_ack[k], exp_gc));
            tick(1);
            e = sb.pop_front(); o = obs(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL wake_step_%0d: got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_simultaneous();
        idle_thresh = 8'd3;
        busy = 1'b0;
        tick(3);
        busy = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL match_vs_demand: got %h exp %h", o, e); end
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(5);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL stay_active: got %h exp %h", o, e); end
        busy = 1'b0;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(3);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL regate_wait: got %h exp %h", o, e); end
        exp_gc++;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, exp_gc));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL regate: got %h exp %h", o, e); end
        busy = 1'b1;
        tick(3);
    endtask

    task automatic test_thresh_change();
        idle_thresh = 8'd8;
        busy = 1'b0;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(5);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL thresh_hi_wait: got %h exp %h", o, e); end
        idle_thresh = 8'd2;
        exp_gc++;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, exp_gc));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL thresh_lowered: got %h exp %h", o, e); end
        busy = 1'b1;
        tick(3);
        idle_thresh = 8'd8;
        busy = 1'b0;
        tick(3);
        idle_thresh = 8'd0;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(20);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL thresh_zero: got %h exp %h", o, e); end
        // A fresh idle run from ACTIVE takes the full threshold
        idle_thresh = 8'd3;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(3);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL fresh_run_wait: got %h exp %h", o, e); end
        exp_gc++;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, exp_gc));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL fresh_run_gate: got %h exp %h", o, e); end
        busy = 1'b1;
        tick(3);
    endtask

    task automatic test_disabled();
        int low_cycles;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_gc = 0;
        for (int pass = 0; pass < 2; pass++) begin
            busy        = 1'b0;
            force_on    = (pass == 1);
            idle_thresh = (pass == 1) ? 8'd5 : 8'd0;
            low_cycles  = 0;
            for (int k = 0; k < 1000; k++) begin
                tick(1);
                if (en !== 1'b1) low_cycles++;
            end
            n_tests++;
            if (low_cycles !== 0) begin
                n_fail++;
                $display("FAIL disabled_en_%0d: en low %0d cycles, required 0", pass, low_cycles);
            end
            sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
            e = sb.pop_front(); o = obs(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL disabled_state_%0d: got %h exp %h", pass, o, e); end
        end
        force_on = 1'b0;
        busy     = 1'b1;
        tick(1);
    endtask

    task automatic test_saturation();
        int k;
        idle_thresh = 8'd1;
        for (int i = 0; i < 20; i++) begin
            busy = 1'b0;
            k = 0;
            while (gated !== 1'b1 && k < 10) begin
                tick(1);
                k++;
            end
            exp_gc++;
            n_tests++;
            if (gated !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_gate_timeout_%0d: gated=%b after %0d cycles, required 1", i, gated, k);
            end
            if (i == 14) begin
                sb.push_back(mk(1'b0, 1'b1, 1'b0, exp_gc));
                e = sb.pop_front(); o = obs(); n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL sat_at_15: got %h exp %h", o, e); end
            end
            busy = 1'b1;
            tick(3);
        end
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL sat_final: got %h exp %h", o, e); end
    endtask

    task automatic test_reset_gated();
        idle_thresh = 8'd2;
        busy = 1'b0;
        exp_gc++;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, exp_gc));
        tick(4);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL pre_reset_gated: got %h exp %h", o, e); end
        rst = 1'b1;
        exp_gc = 0;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, exp_gc));
        tick(1);
        e = sb.pop_front(); o = obs(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_from_gated: got %h exp %h", o, e); end
        rst = 1'b0;
        busy = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_gating_latency();
        test_wake();
        test_simultaneous();
        test_thresh_change();
        test_disabled();
        test_saturation();
        test_reset_gated();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
